// File: rtl/moore_fsm_pkg.sv
// Shared definitions for the 1,0,0,1 Moore sequence detector:
// pattern length and the 3-bit state encoding.
package moore_fsm_pkg;

    // Number of serial bits in the detected pattern 1,0,0,1.
    localparam int PATTERN_LEN = 4;

    // Each state records how many pattern bits have been matched so far,
    // so the "fully matched" state encodes as the pattern length.
    typedef enum logic [2:0] {
        S0 = 3'd0,               // no progress
        S1 = 3'd1,               // seen "1"
        S2 = 3'd2,               // seen "10"
        S3 = 3'd3,               // seen "100"
        S4 = 3'(PATTERN_LEN)     // seen "1001" -> detect
    } state_t;

    // Detect flag decode: asserted only in the matched state.
    function automatic logic is_match_state(input state_t st);
        logic match_s;
        if (st == S4) begin
            match_s = 1'b1;
        end else begin
            match_s = 1'b0;
        end
        return match_s;
    endfunction

endpackage : moore_fsm_pkg

// File: rtl/moore_fsm.sv
// Moore detector for the serial pattern 1,0,0,1 with overlapping matches.
// z depends on the current state only; a never reaches z combinationally.
module moore_fsm
    import moore_fsm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a,
    output logic z
);

    state_t r_state;
    state_t w_next;
    logic   w_z;

    // State register: asynchronous reset forces S0 immediately, no clock needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S0;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; anything unexpected (encodings 5..7) falls back to S0.
    always_comb begin
        w_next = S0;
        case (r_state)
            S0:      w_next = a ? S1 : S0;
            S1:      w_next = a ? S1 : S2;   // runs of 1s keep the "1" prefix
            S2:      w_next = a ? S1 : S3;
            S3:      w_next = a ? S4 : S0;   // third 0 loses all progress
            S4:      w_next = a ? S1 : S2;   // trailing 1 seeds the next match
            default: w_next = S0;
        endcase
    end

    // Output decode from the registered state only.
    always_comb begin
        w_z = 1'b0;
        w_z = is_match_state(r_state);
    end

    assign z = w_z;

endmodule : moore_fsm

// File: tb/tb_moore_fsm.sv
// Self-checking bench for moore_fsm: a shift-history reference model pushes
// the expected z for each driven bit; the value is popped and compared
// shortly after the rising edge that samples the bit.
module tb_moore_fsm;
    import moore_fsm_pkg::*;

    localparam logic [3:0] PATTERN = 4'b1001;

    logic clk;
    logic rst;
    logic a;
    logic z;

    int n_checks;
    int n_fails;

    // Reference model: last sampled bits and how many were seen since reset.
    logic [3:0] m_hist;
    int         m_cnt;
    logic       exp_q[$];
    logic       m_cur;

    moore_fsm dut (
        .clk(clk),
        .rst(rst),
        .a  (a),
        .z  (z)
    );

    // 100 ns clock.
    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check_val(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: z=%b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Clear the model progress (mirrors any reset of the DUT).
    task automatic model_clear();
        m_hist = 4'b0000;
        m_cnt  = 0;
        m_cur  = 1'b0;
    endtask

    // Drive one bit at the falling edge, push its expectation, check after the rising edge.
    task automatic step(input string tag, input logic bit_in);
        logic exp_v;
        @(negedge clk);
        a = bit_in;
        m_hist = {m_hist[2:0], bit_in};
        m_cnt++;
        exp_q.push_back((m_cnt >= PATTERN_LEN) && (m_hist == PATTERN));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL %s: scoreboard empty, z=%b", tag, z);
        end else begin
            exp_v = exp_q.pop_front();
            m_cur = exp_v;
            check_val(tag, z, exp_v);
        end
    endtask

    // Drive a whole sequence, packed MSB-first in seq with len bits.
    task automatic run_seq(input string tag, input logic [15:0] seq, input int len);
        logic [15:0] s;
        s = seq;
        for (int i = len - 1; i >= 0; i--) begin
            step(tag, s[i]);
        end
    endtask

    // Asynchronous reset pulse of 20 ns between clock edges; z must drop at once.
    task automatic pulse_reset(input string tag);
        #20;
        rst = 1'b1;
        #5;
        check_val({tag, "_async"}, z, 1'b0);
        #15;
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        model_clear();
        a   = 1'b0;
        rst = 1'b1;

        // Reset with clock edges irrelevant: z low immediately.
        #10;
        check_val("reset_idle", z, 1'b0);
        #20;
        rst = 1'b0;

        // Basic detect: 1,0,0,1 -> z only after the fourth edge.
        run_seq("basic", 16'b1001, 4);

        // Async reset while in S4 forces z low without a clock edge.
        pulse_reset("reset_in_s4");

        // Full stream: z after edges 5 and 13 only.
        run_seq("stream", 16'b1100_1000_0100_1010, 16);

        // Overlap: 1,0,0,1,0,0,1 -> z after edges 4 and 7.
        pulse_reset("pre_overlap");
        run_seq("overlap", 16'b100_1001, 7);

        // Near misses, each from a clean start.
        pulse_reset("pre_nm1");
        run_seq("near_101", 16'b101, 3);
        pulse_reset("pre_nm2");
        run_seq("near_10001", 16'b10001, 5);
        pulse_reset("pre_nm3");
        run_seq("near_1111", 16'b1111, 4);

        // Mid-operation reset discards "100"; the following 1 must not detect.
        pulse_reset("pre_mid");
        run_seq("mid_pre", 16'b100, 3);
        pulse_reset("mid_rst");
        run_seq("mid_post", 16'b1001, 4);

        // Output stability: sit in S3 and toggle a between edges.
        pulse_reset("pre_stab");
        run_seq("stab_pre", 16'b100, 3);
        for (int k = 0; k < 4; k++) begin
            #7;
            a = ~a;
            #1;
            check_val("stab_toggle", z, m_cur);
        end
        step("stab_hit", 1'b1);
        step("stab_after", 1'b1);

        // A few random bits against the model.
        for (int r = 0; r < 24; r++) begin
            step("random", 1'($urandom_range(1, 0)));
        end

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL leftover: %0d expectations not consumed, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_moore_fsm
